// File: rtl/mem_req_master_pkg.sv
// Shared defaults, FSM state type and count-width helper for the memory request master.
package mem_req_master_pkg;

  localparam int AW_DEF        = 4;
  localparam int DW_DEF        = 8;
  localparam int RSP_DEPTH_DEF = 4;
  localparam int CNT_W         = $clog2(RSP_DEPTH_DEF + 1);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/mem_req_master_rsp_fifo.sv
// Synchronous response FIFO; push and pop may coincide at any occupancy.
module rsp_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Explicit wrap so non-power-of-two depths stay in range.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_next(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_next(rd_ptr_q);
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/mem_req_master.sv
// Initiator for a two-port synchronous memory: optional zero-fill sweep after reset,
// then valid/ready commands in and in-order read responses out.
module mem_req_master
  import mem_req_master_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int RSP_DEPTH = RSP_DEPTH_DEF,
  parameter bit INIT_EN   = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          init_done,
  output logic [AW-1:0] mem_waddr,
  output logic [AW-1:0] mem_raddr,
  output logic          mem_wren,
  output logic          mem_rden,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  // Both channels use the same handshake: a transfer happens at a posedge where
  // valid && ready; valid never waits on ready, and ready never looks at valid.

  localparam int CW = cnt_width(RSP_DEPTH);

  state_e        state_q, state_d;
  logic [AW-1:0] sweep_q, sweep_d;
  logic          init_done_q, init_done_d;
  logic          mem_wren_q, mem_wren_d;
  logic          mem_rden_q, mem_rden_d;
  logic [AW-1:0] mem_waddr_q, mem_waddr_d;
  logic [AW-1:0] mem_raddr_q, mem_raddr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          s1_q, s1_d;
  logic          s2_q, s2_d;

  logic [CW-1:0] fifo_count;
  logic          cmd_accept;
  logic          rsp_pop;

  // Reads in s1/s2 already own a FIFO slot, so credits count them too.
  assign cmd_ready  = (state_q == ST_RUN) && init_done_q &&
                      ((int'(fifo_count) + int'(s1_q) + int'(s2_q)) < RSP_DEPTH);
  assign cmd_accept = cmd_valid && cmd_ready;
  assign rsp_valid  = (fifo_count != '0);
  assign rsp_pop    = rsp_valid && rsp_ready;

  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    init_done_d = init_done_q;
    mem_wren_d  = 1'b0;
    mem_rden_d  = 1'b0;
    mem_waddr_d = mem_waddr_q;
    mem_raddr_d = mem_raddr_q;
    mem_wdata_d = mem_wdata_q;
    s1_d        = 1'b0;
    s2_d        = s1_q;
    case (state_q)
      ST_INIT: begin
        mem_wren_d  = 1'b1;
        mem_waddr_d = sweep_q;
        mem_wdata_d = '0;
        sweep_d     = sweep_q + AW'(1);
        if (sweep_q == {AW{1'b1}}) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end
      end
      ST_RUN: begin
        init_done_d = 1'b1;
        if (cmd_accept) begin
          if (cmd_write) begin
            mem_wren_d  = 1'b1;
            mem_waddr_d = cmd_addr;
            mem_wdata_d = cmd_wdata;
          end else begin
            mem_rden_d  = 1'b1;
            mem_raddr_d = cmd_addr;
            s1_d        = 1'b1;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT_EN ? ST_INIT : ST_RUN;
      sweep_q     <= '0;
      init_done_q <= 1'b0;
      mem_wren_q  <= 1'b0;
      mem_rden_q  <= 1'b0;
      mem_waddr_q <= '0;
      mem_raddr_q <= '0;
      mem_wdata_q <= '0;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      init_done_q <= init_done_d;
      mem_wren_q  <= mem_wren_d;
      mem_rden_q  <= mem_rden_d;
      mem_waddr_q <= mem_waddr_d;
      mem_raddr_q <= mem_raddr_d;
      mem_wdata_q <= mem_wdata_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
    end
  end

  // s2 marks the cycle in which mem_rdata holds the data for the oldest read.
  rsp_fifo #(
    .DW    (DW),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (s2_q),
    .push_data (mem_rdata),
    .pop       (rsp_pop),
    .pop_data  (rsp_data),
    .count     (fifo_count)
  );

  assign init_done = init_done_q;
  assign mem_wren  = mem_wren_q;
  assign mem_rden  = mem_rden_q;
  assign mem_waddr = mem_waddr_q;
  assign mem_raddr = mem_raddr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_req_master.sv
// Directed bench for mem_req_master with a behavioural two-port memory and a response scoreboard.
module tb_mem_req_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [3:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       init_done;
  logic [3:0] mem_waddr;
  logic [3:0] mem_raddr;
  logic       mem_wren;
  logic       mem_rden;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  logic [7:0] bmem [16];
  logic [7:0] ref_mem [16];
  logic [7:0] exp_q [$];

  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;
  int n_rsp = 0;
  int rd_addr;

  mem_req_master dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .init_done (init_done),
    .mem_waddr (mem_waddr),
    .mem_raddr (mem_raddr),
    .mem_wren  (mem_wren),
    .mem_rden  (mem_rden),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Registered-read memory: read data appears the cycle after the address is sampled.
  always @(posedge clk) begin
    if (mem_wren) bmem[mem_waddr] <= mem_wdata;
    if (mem_rden) mem_rdata <= bmem[mem_raddr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with inputs already driven; scores this edge's handshakes,
  // then advances to the next negedge.
  task automatic cyc();
    logic [7:0] e;
    if (rsp_valid && rsp_ready) begin
      n_rsp++;
      chk("rsp_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rsp_data", {24'd0, rsp_data}, {24'd0, e});
      end
    end
    if (cmd_valid && cmd_ready && rst_n) begin
      n_acc++;
      if (cmd_write) ref_mem[cmd_addr] = cmd_wdata;
      else exp_q.push_back(ref_mem[cmd_addr]);
    end
    chk("wren_rden_excl", {31'd0, mem_wren && mem_rden}, 32'd0);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    cmd_valid = 1'b0;
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) cyc();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk(tag, {3'd0, cmd_ready, rsp_valid, rsp_data, init_done, mem_wren, mem_rden,
              mem_waddr, mem_raddr, mem_wdata}, 32'd0);
  endtask

  task automatic check_sweep();
    for (int k = 0; k < 16; k++) begin
      cyc();
      chk("sweep_write", {18'd0, mem_wren, mem_waddr, mem_wdata, rsp_valid},
          {18'd0, 1'b1, k[3:0], 8'h00, 1'b0});
      if (k < 15) chk("sweep_not_done", {30'd0, init_done, cmd_ready}, 32'd0);
    end
    cyc();
    chk("sweep_done", {29'd0, init_done, cmd_ready, mem_wren}, {29'd0, 3'b110});
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b1;

    // Reset and INIT sweep
    @(negedge clk);
    check_reset_vals("reset_vals");
    @(negedge clk);
    rst_n = 1'b1;
    check_sweep();

    // Write then back-to-back read of the same address
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'd3; cmd_wdata = 8'h5A;
    cyc();
    chk("wr_drive", {19'd0, mem_wren, mem_waddr, mem_wdata}, {19'd0, 1'b1, 4'd3, 8'h5A});
    cmd_write = 1'b0; cmd_addr = 4'd3;
    cyc();
    chk("rd_drive", {26'd0, mem_rden, mem_wren, mem_raddr}, {26'd0, 1'b1, 1'b0, 4'd3});
    cmd_valid = 1'b0;
    chk("raw_lat0", rsp_valid, 0);
    cyc();
    chk("raw_lat1", {30'd0, rsp_valid, mem_rden}, 32'd0);
    cyc();
    chk("raw_lat2", rsp_valid, 1);
    chk("raw_head", rsp_data, 8'h5A);
    drain();

    // Read of a swept address
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'd7;
    cyc();
    drain();
    chk("init_rd_rsp_total", n_rsp, 2);

    // Credit stall with the response channel blocked
    cmd_valid = 1'b1; cmd_write = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cmd_addr = i[3:0]; cmd_wdata = 8'h10 + i[7:0];
      cyc();
    end
    rsp_ready = 1'b0; cmd_write = 1'b0; n_acc = 0; rd_addr = 0;
    for (int i = 0; i < 8; i++) begin
      cmd_addr = rd_addr[3:0];
      if (cmd_ready) rd_addr++;
      cyc();
    end
    chk("stall_accepts", n_acc, 4);
    chk("stall_ready", cmd_ready, 0);
    chk("stall_head", {23'd0, rsp_valid, rsp_data}, {23'd0, 1'b1, 8'h10});
    cyc();
    chk("stall_hold", {23'd0, rsp_valid, rsp_data}, {23'd0, 1'b1, 8'h10});
    rsp_ready = 1'b1;
    for (int i = 0; i < 20 && rd_addr < 6; i++) begin
      cmd_addr = rd_addr[3:0];
      if (cmd_ready) rd_addr++;
      cyc();
    end
    cmd_valid = 1'b0;
    chk("resume_accepts", n_acc, 6);
    drain();

    // Full-rate reads
    cmd_valid = 1'b1; cmd_write = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cmd_addr = i[3:0]; cmd_wdata = 8'(i * 3);
      cyc();
    end
    cmd_write = 1'b0; n_acc = 0; n_rsp = 0;
    for (int i = 0; i < 16; i++) begin
      cmd_addr = i[3:0];
      cyc();
    end
    chk("b2b_accepts", n_acc, 16);
    drain();
    chk("b2b_rsp_count", n_rsp, 16);

    // Reset with reads in flight and a response pending
    rsp_ready = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b0;
    for (int i = 1; i < 4; i++) begin
      cmd_addr = i[3:0];
      cyc();
    end
    cmd_valid = 1'b0;
    chk("pre_reset_state", {29'd0, rsp_valid, mem_rden, init_done}, {29'd0, 3'b111});
    rst_n = 1'b0;
    #1;
    check_reset_vals("midop_reset_vals");
    exp_q.delete();
    rsp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    check_sweep();
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("no_ghost_rsp", rsp_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
